// File: rtl/pe_s10_tree_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : pe_s10_tree_feeder
//  Description : Stream-to-vector front end for an external free-running
//                signed adder tree. Gathers NUM elements from a valid/ready
//                stream, launches them into the tree, waits out the fixed
//                tree latency and presents the sum on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_s10_tree_feeder #(
    parameter int SIZE     = 5,
    parameter int NUM      = 40,
    parameter int TREE_LAT = $clog2(NUM)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic signed [SIZE-1:0]             in_data,
    output logic                               in_ready,
    output logic signed [SIZE-1:0]             tree_din [0:NUM-1],
    input  logic signed [$clog2(NUM)+SIZE-1:0] tree_dout,
    output logic                               out_valid,
    output logic signed [$clog2(NUM)+SIZE-1:0] out_data,
    input  logic                               out_ready
);

    localparam int c_cnt_w = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int c_lat_w = (TREE_LAT > 0) ? $clog2(TREE_LAT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM - 1);
    localparam logic [c_lat_w-1:0] c_lat  = c_lat_w'(TREE_LAT);

    // Gather buffer and its bookkeeping
    logic signed [SIZE-1:0] r_buf [0:NUM-1];
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_full;

    // In-flight tracking: at most one vector inside the tree at a time
    logic                   r_busy;
    logic [c_lat_w-1:0]     r_lat;

    logic w_accept;
    logic w_launch;
    logic w_capture;
    logic w_consume;

    // Input is only refused while a complete vector waits for launch
    assign in_ready  = ~r_full;
    assign w_accept  = in_valid & ~r_full;
    // A held result blocks launch so the single result register is never overrun
    assign w_launch  = r_full & ~r_busy & ~out_valid;
    assign w_capture = r_busy & (r_lat == '0);
    assign w_consume = out_valid & out_ready;

    // Gather: write elements in arrival order, flag a complete vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf[r_cnt] <= in_data;
                if (r_cnt == c_last) begin
                    r_cnt  <= '0;
                    r_full <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + c_cnt_w'(1);
                end
            end else if (w_launch) begin
                // Buffer is copied out, so the next vector may start filling
                r_full <= 1'b0;
            end
        end
    end

    // Launch and latency tracking: tree_din only changes on a launch edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                tree_din[i] <= '0;
            end
            r_busy <= 1'b0;
            r_lat  <= '0;
        end else begin
            if (w_launch) begin
                tree_din <= r_buf;
                r_busy   <= 1'b1;
                r_lat    <= c_lat;
            end else if (r_busy) begin
                if (r_lat != '0) begin
                    r_lat <= r_lat - c_lat_w'(1);
                end else begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Result register: capture the tree sum, hold it until consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (w_capture) begin
                out_data  <= tree_dout;
                out_valid <= 1'b1;
            end else if (w_consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_s10_tree_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_s10_tree_feeder
//  Description : Self-checking bench for pe_s10_tree_feeder with a NUM=4 and
//                a NUM=3 instance, each driving a behavioural adder tree.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_s10_tree_feeder;

    localparam int SIZE = 5;
    localparam int NA   = 4;
    localparam int LA   = $clog2(NA);
    localparam int WA   = LA + SIZE;
    localparam int NB   = 3;
    localparam int LB   = $clog2(NB);
    localparam int WB   = LB + SIZE;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic                   in_valid_a = 1'b0;
    logic signed [SIZE-1:0] in_data_a  = '0;
    logic                   in_ready_a;
    logic signed [SIZE-1:0] tree_din_a [0:NA-1];
    logic signed [WA-1:0]   tree_dout_a;
    logic                   out_valid_a;
    logic signed [WA-1:0]   out_data_a;
    logic                   out_ready_a = 1'b0;

    logic                   in_valid_b = 1'b0;
    logic signed [SIZE-1:0] in_data_b  = '0;
    logic                   in_ready_b;
    logic signed [SIZE-1:0] tree_din_b [0:NB-1];
    logic signed [WB-1:0]   tree_dout_b;
    logic                   out_valid_b;
    logic signed [WB-1:0]   out_data_b;
    logic                   out_ready_b = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit prev_ov = 1'b0;
    int res_cyc[$];
    int res_val[$];

    always #5 clk = ~clk;

    pe_s10_tree_feeder #(.SIZE(SIZE), .NUM(NA)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .tree_din  (tree_din_a),
        .tree_dout (tree_dout_a),
        .out_valid (out_valid_a),
        .out_data  (out_data_a),
        .out_ready (out_ready_a)
    );

    pe_s10_tree_feeder #(.SIZE(SIZE), .NUM(NB)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .tree_din  (tree_din_b),
        .tree_dout (tree_dout_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_ready (out_ready_b)
    );

    // Behavioural free-running trees: sum delayed by L register stages, no reset
    logic signed [WA-1:0] pipe_a [0:LA-1];
    logic signed [WB-1:0] pipe_b [0:LB-1];

    function automatic int sum_a();
        int s = 0;
        for (int i = 0; i < NA; i++) s += int'(tree_din_a[i]);
        return s;
    endfunction

    function automatic int sum_b();
        int s = 0;
        for (int i = 0; i < NB; i++) s += int'(tree_din_b[i]);
        return s;
    endfunction

    always @(posedge clk) begin
        pipe_a[0] <= WA'(sum_a());
        for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= WB'(sum_b());
        for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign tree_dout_a = pipe_a[LA-1];
    assign tree_dout_b = pipe_b[LB-1];

    // Advance one edge, sample 1 ns later, log every new result on instance A
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (out_valid_a && !prev_ov) begin
            res_cyc.push_back(cyc);
            res_val.push_back(int'(out_data_a));
        end
        prev_ov = out_valid_a;
    endtask

    task automatic do_reset();
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        res_cyc.delete();
        res_val.delete();
    endtask

    // Present one element on A until accepted; acc = edge of acceptance or -1000
    task automatic feed_a(input int d, output int acc);
        bit hs;
        acc = -1000;
        hs  = 1'b0;
        in_valid_a = 1'b1;
        in_data_a  = SIZE'(d);
        for (int t = 0; t < 40 && !hs; t++) begin
            hs = in_ready_a;
            step();
            if (hs) acc = cyc;
        end
        in_valid_a = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_a);
        end
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_a);
        end
        checks++;
        if (out_data_a !== '0) begin
            errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data_a);
        end
        bad = 0;
        for (int i = 0; i < NA; i++) if (tree_din_a[i] !== '0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_tree_din: got %0d nonzero entries expected 0", bad);
        end
        checks++;
        if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0) begin
            errors++; $display("FAIL reset_b: got ready=%0b valid=%0b expected 1/0", in_ready_b, out_valid_b);
        end
    endtask

    task automatic test_basic();
        int acc;
        int v;
        int c;
        do_reset();
        out_ready_a = 1'b1;
        for (int k = 1; k <= 4; k++) feed_a(k, acc);
        for (int t = 0; t < 20 && res_val.size() == 0; t++) step();
        v = (res_val.size() > 0) ? res_val[0] : -9999;
        c = (res_cyc.size() > 0) ? res_cyc[0] - acc : -9999;
        checks++;
        if (v != 10) begin
            errors++; $display("FAIL basic_sum: got %0d expected 10", v);
        end
        checks++;
        if (c != 4) begin
            errors++; $display("FAIL basic_latency: got %0d edges expected 4", c);
        end
        checks++;
        if (int'(tree_din_a[0]) != 1 || int'(tree_din_a[1]) != 2 ||
            int'(tree_din_a[2]) != 3 || int'(tree_din_a[3]) != 4) begin
            errors++;
            $display("FAIL basic_tree_din: got {%0d,%0d,%0d,%0d} expected {1,2,3,4}",
                     tree_din_a[0], tree_din_a[1], tree_din_a[2], tree_din_a[3]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        int v0;
        int v1;
        do_reset();
        out_ready_a = 1'b1;
        for (int k = 0; k < 4; k++) feed_a(-16, acc1);
        for (int k = 0; k < 4; k++) feed_a(15, acc2);
        for (int t = 0; t < 30 && res_val.size() < 2; t++) step();
        v0 = (res_val.size() > 0) ? res_val[0] : -9999;
        v1 = (res_val.size() > 1) ? res_val[1] : -9999;
        checks++;
        if (v0 != -64) begin
            errors++; $display("FAIL b2b_first: got %0d expected -64", v0);
        end
        checks++;
        if (v1 != 60) begin
            errors++; $display("FAIL b2b_second: got %0d expected 60", v1);
        end
        checks++;
        if (res_cyc.size() < 2 || res_cyc[0] - acc1 != 4 || res_cyc[1] - acc2 != 4) begin
            errors++;
            $display("FAIL b2b_latency: got %0d results (first at +%0d) expected 2 at +4 each",
                     res_cyc.size(), (res_cyc.size() > 0) ? res_cyc[0] - acc1 : -1);
        end
        step();
    endtask

    task automatic test_backpressure();
        int acc;
        int h;
        int v;
        int c;
        do_reset();
        out_ready_a = 1'b0;
        for (int k = 1; k <= 8; k++) feed_a(k, acc);
        step();
        step();
        checks++;
        if (in_ready_a !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready_a);
        end
        checks++;
        if (out_valid_a !== 1'b1 || int'(out_data_a) != 10) begin
            errors++; $display("FAIL bp_held: got valid=%0b data=%0d expected 1/10", out_valid_a, out_data_a);
        end
        out_ready_a = 1'b1;
        step();
        h = cyc;
        out_ready_a = 1'b0;
        for (int t = 0; t < 20 && res_val.size() < 2; t++) step();
        v = (res_val.size() > 1) ? res_val[1] : -9999;
        c = (res_cyc.size() > 1) ? res_cyc[1] - h : -9999;
        checks++;
        if (v != 26) begin
            errors++; $display("FAIL bp_second: got %0d expected 26", v);
        end
        checks++;
        if (c != 4) begin
            errors++; $display("FAIL bp_relaunch_latency: got %0d edges expected 4", c);
        end
        out_ready_a = 1'b1;
        step();
    endtask

    task automatic test_num3();
        int vals[3] = '{7, -3, 5};
        int acc;
        int seen;
        int got;
        do_reset();
        out_ready_b = 1'b1;
        acc  = -1000;
        seen = -1;
        got  = -9999;
        for (int k = 0; k < 3; k++) begin
            bit hs;
            hs = 1'b0;
            in_valid_b = 1'b1;
            in_data_b  = SIZE'(vals[k]);
            for (int t = 0; t < 20 && !hs; t++) begin
                hs = in_ready_b;
                step();
            end
            acc = hs ? cyc : -1000;
        end
        in_valid_b = 1'b0;
        for (int t = 0; t < 20 && seen < 0; t++) begin
            step();
            if (out_valid_b) begin
                seen = cyc;
                got  = int'(out_data_b);
            end
        end
        checks++;
        if (got != 9) begin
            errors++; $display("FAIL num3_sum: got %0d expected 9", got);
        end
        checks++;
        if (seen - acc != 4) begin
            errors++; $display("FAIL num3_latency: got %0d edges expected 4", seen - acc);
        end
        checks++;
        if (int'(tree_din_b[0]) != 7 || int'(tree_din_b[1]) != -3 || int'(tree_din_b[2]) != 5) begin
            errors++;
            $display("FAIL num3_tree_din: got {%0d,%0d,%0d} expected {7,-3,5}",
                     tree_din_b[0], tree_din_b[1], tree_din_b[2]);
        end
        step();
    endtask

    task automatic test_async_reset();
        int acc;
        int v;
        int c;
        do_reset();
        out_ready_a = 1'b0;
        for (int k = 1; k <= 6; k++) feed_a(k, acc);
        step();
        step();
        checks++;
        if (out_valid_a !== 1'b1) begin
            errors++; $display("FAIL areset_pre_valid: got %0b expected 1", out_valid_a);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got ready=%0b valid=%0b data=%0d expected 1/0/0",
                     in_ready_a, out_valid_a, out_data_a);
        end
        step();
        reset = 1'b0;
        res_cyc.delete();
        res_val.delete();
        out_ready_a = 1'b1;
        for (int k = 0; k < 4; k++) feed_a(1, acc);
        for (int t = 0; t < 20 && res_val.size() == 0; t++) step();
        v = (res_val.size() > 0) ? res_val[0] : -9999;
        c = (res_cyc.size() > 0) ? res_cyc[0] - acc : -9999;
        checks++;
        if (v != 4 || c != 4) begin
            errors++; $display("FAIL areset_restart: got %0d at +%0d expected 4 at +4", v, c);
        end
        step();
    endtask

    task automatic test_reset_in_flight();
        int acc;
        int v;
        do_reset();
        out_ready_a = 1'b1;
        for (int k = 1; k <= 4; k++) feed_a(k, acc);
        step();
        step();
        #2;
        reset = 1'b1;
        step();
        reset = 1'b0;
        res_cyc.delete();
        res_val.delete();
        feed_a(0, acc);
        feed_a(0, acc);
        feed_a(0, acc);
        feed_a(1, acc);
        for (int t = 0; t < 15; t++) step();
        v = (res_val.size() > 0) ? res_val[0] : -9999;
        checks++;
        if (res_val.size() != 1) begin
            errors++; $display("FAIL flight_reset_count: got %0d results expected 1", res_val.size());
        end
        checks++;
        if (v != 1) begin
            errors++; $display("FAIL flight_reset_value: got %0d expected 1", v);
        end
    endtask

    // Random traffic scored against a queue model of vectors and their sums
    task automatic test_random();
        int elems[$];
        int exp_sum[$];
        int exp_vec[$];
        int accepted;
        int produced;
        int s;
        int bad;
        do_reset();
        accepted = 0;
        produced = 0;
        for (int t = 0; t < 450; t++) begin
            bit in_hs;
            bit out_hs;
            bit drain;
            drain = (t >= 400);
            in_valid_a  = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
            in_data_a   = SIZE'($urandom_range(0, 31));
            out_ready_a = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
            #1;
            in_hs  = in_valid_a && in_ready_a;
            out_hs = out_valid_a && out_ready_a;
            if (out_hs) begin
                checks++;
                if (exp_sum.size() == 0) begin
                    errors++; $display("FAIL rand_extra_result: got %0d expected none", out_data_a);
                end else begin
                    s = exp_sum.pop_front();
                    bad = 0;
                    for (int i = 0; i < NA; i++) if (int'(tree_din_a[i]) != exp_vec.pop_front()) bad++;
                    if (int'(out_data_a) != s || bad != 0) begin
                        errors++;
                        $display("FAIL rand_result: got sum %0d (%0d lanes off) expected sum %0d",
                                 out_data_a, bad, s);
                    end
                end
                produced++;
            end
            if (in_hs) begin
                elems.push_back(int'(in_data_a));
                accepted++;
                if (elems.size() == NA) begin
                    s = 0;
                    for (int i = 0; i < NA; i++) begin
                        s += elems[i];
                        exp_vec.push_back(elems[i]);
                    end
                    exp_sum.push_back(s);
                    elems.delete();
                end
            end
            @(posedge clk);
            cyc++;
            #0;
        end
        checks++;
        if (produced != accepted / NA || produced == 0) begin
            errors++; $display("FAIL rand_count: got %0d results expected %0d", produced, accepted / NA);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_num3();
        test_async_reset();
        test_reset_in_flight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
